// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : shared widths, reset PC and decoder instruction field positions
// Revision: 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  localparam int COND_HI     = 15;
  localparam int COND_LO     = 14;
  localparam int OP_CODE_HI  = 13;
  localparam int OP_CODE_LO  = 10;
  localparam int DEST_HI     = 9;
  localparam int DEST_LO     = 7;
  localparam int SRC1_HI     = 6;
  localparam int SRC1_LO     = 4;
  localparam int SRC2_HI     = 3;
  localparam int SRC2_LO     = 1;
  localparam int SHIFT_BIT   = 0;

  function automatic logic [3:0] op_code_of(input logic [INST_W-1:0] inst);
    return inst[OP_CODE_HI:OP_CODE_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : 2-entry FIFO of {inst, pc}; slot 0 is always the head
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int INST_W = cpu_pkg::INST_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [INST_W-1:0] head_inst,
  output logic [ADDR_W-1:0] head_pc,
  output logic [1:0]        count
);

  logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            inst0_d = push_inst;
            pc0_d   = push_pc;
          end else begin
            inst1_d = push_inst;
            pc1_d   = push_pc;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          inst0_d = inst1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Full queue: shift the second entry up and append behind it
          if (count_q == 2'd2) begin
            inst0_d = inst1_q;
            pc0_d   = pc1_q;
            inst1_d = push_inst;
            pc1_d   = push_pc;
          end else begin
            inst0_d = push_inst;
            pc0_d   = push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst0_q <= '0;
      inst1_q <= '0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      count_q <= 2'd0;
    end else begin
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      count_q <= count_d;
    end
  end

  assign head_inst = inst0_q;
  assign head_pc   = pc0_q;
  assign count     = count_q;

`ifndef SYNTHESIS
  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && (count_q == 2'd2)));
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : PC, fixed-latency imem request issue and in-flight tracking
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              pop, push;

  always_comb begin
    inst_valid = (count != 2'd0) && !redirect_valid;
    pop        = inst_valid && inst_ready;
    // Slots committed after this edge; issuing keeps it at or below queue depth
    occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    imem_req   = !rst && !redirect_valid && (occupancy < 3'd2);
    imem_addr  = pc_q;
    push       = inflight_q && !redirect_valid;

    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_inst (imem_rdata),
    .push_pc   (inflight_pc_q),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_inst (inst),
    .head_pc   (inst_pc),
    .count     (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : table-driven cycle vectors plus stall/async-reset sequence
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [7:0]  inst_pc;

  logic        w_req;
  logic [7:0]  w_addr;
  logic [15:0] w_rdata;
  logic        w_valid;
  logic [15:0] w_inst;
  logic [7:0]  w_pc;
  logic        w_redirect = 1'b0;
  logic [7:0]  w_redirect_pc = 8'h00;
  logic        w_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  // Memory returns word[a] = 0xA000 + a one cycle after the address
  always @(posedge clk) begin
    imem_rdata <= 16'hA000 + {8'h00, imem_addr};
    w_rdata    <= 16'hA000 + {8'h00, w_addr};
  end

  fetch_unit #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  fetch_unit #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect_valid(w_redirect),
    .redirect_pc(w_redirect_pc), .inst_valid(w_valid), .inst_ready(w_ready),
    .inst(w_inst), .inst_pc(w_pc)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [7:0]  rpc;
    logic        req;
    logic [7:0]  addr;
    logic        v;
    logic [15:0] inst;
    logic [7:0]  ipc;
  } vec_t;

  vec_t       vecs[24];
  logic [7:0] wrap_addr_exp[4];
  logic [7:0] wrap_pc_exp[4];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [7:0] rpc,
                              input logic req, input logic [7:0] addr, input logic v,
                              input logic [15:0] i, input logic [7:0] ipc);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.req = req;
    r.addr = addr; r.v = v; r.inst = i; r.ipc = ipc;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00);
    vecs[1]  = mk(1, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h00);
    vecs[2]  = mk(1, 0, 8'h00, 1, 8'h02, 1, 16'hA000, 8'h00);
    vecs[3]  = mk(1, 0, 8'h00, 1, 8'h03, 1, 16'hA001, 8'h01);
    vecs[4]  = mk(1, 0, 8'h00, 1, 8'h04, 1, 16'hA002, 8'h02);
    vecs[5]  = mk(0, 0, 8'h00, 0, 8'h05, 1, 16'hA003, 8'h03);
    vecs[6]  = mk(0, 0, 8'h00, 0, 8'h05, 1, 16'hA003, 8'h03);
    vecs[7]  = mk(0, 0, 8'h00, 0, 8'h05, 1, 16'hA003, 8'h03);
    vecs[8]  = mk(0, 0, 8'h00, 0, 8'h05, 1, 16'hA003, 8'h03);
    vecs[9]  = mk(0, 0, 8'h00, 0, 8'h05, 1, 16'hA003, 8'h03);
    vecs[10] = mk(1, 0, 8'h00, 1, 8'h05, 1, 16'hA003, 8'h03);
    vecs[11] = mk(1, 0, 8'h00, 1, 8'h06, 1, 16'hA004, 8'h04);
    vecs[12] = mk(1, 0, 8'h00, 1, 8'h07, 1, 16'hA005, 8'h05);
    vecs[13] = mk(1, 1, 8'h40, 0, 8'h08, 0, 16'h0000, 8'h00);
    vecs[14] = mk(1, 0, 8'h00, 1, 8'h40, 0, 16'h0000, 8'h00);
    vecs[15] = mk(1, 0, 8'h00, 1, 8'h41, 0, 16'h0000, 8'h00);
    vecs[16] = mk(1, 0, 8'h00, 1, 8'h42, 1, 16'hA040, 8'h40);
    vecs[17] = mk(1, 0, 8'h00, 1, 8'h43, 1, 16'hA041, 8'h41);
    vecs[18] = mk(1, 1, 8'h10, 0, 8'h44, 0, 16'h0000, 8'h00);
    vecs[19] = mk(1, 1, 8'h20, 0, 8'h10, 0, 16'h0000, 8'h00);
    vecs[20] = mk(1, 0, 8'h00, 1, 8'h20, 0, 16'h0000, 8'h00);
    vecs[21] = mk(1, 0, 8'h00, 1, 8'h21, 0, 16'h0000, 8'h00);
    vecs[22] = mk(1, 0, 8'h00, 1, 8'h22, 1, 16'hA020, 8'h20);
    vecs[23] = mk(1, 0, 8'h00, 1, 8'h23, 1, 16'hA021, 8'h21);

    wrap_addr_exp[0] = 8'hFE; wrap_addr_exp[1] = 8'hFF;
    wrap_addr_exp[2] = 8'h00; wrap_addr_exp[3] = 8'h01;
    wrap_pc_exp[0]   = 8'hFE; wrap_pc_exp[1]   = 8'hFF;
    wrap_pc_exp[2]   = 8'h00; wrap_pc_exp[3]   = 8'h01;

    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset.imem_req",   {15'd0, imem_req},   16'd0);
    check("reset.inst_valid", {15'd0, inst_valid}, 16'd0);
    check("reset.inst",       inst,                16'h0000);
    check("reset.inst_pc",    {8'd0, inst_pc},     16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      inst_ready     = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("c%0d.imem_req", i),   {15'd0, imem_req},   {15'd0, vecs[i].req});
      check($sformatf("c%0d.imem_addr", i),  {8'd0, imem_addr},   {8'd0, vecs[i].addr});
      check($sformatf("c%0d.inst_valid", i), {15'd0, inst_valid}, {15'd0, vecs[i].v});
      if (vecs[i].v) begin
        check($sformatf("c%0d.inst", i),    inst,              vecs[i].inst);
        check($sformatf("c%0d.inst_pc", i), {8'd0, inst_pc},   {8'd0, vecs[i].ipc});
      end
      if (i < 4) begin
        check($sformatf("wrap%0d.imem_req", i),  {15'd0, w_req}, 16'd1);
        check($sformatf("wrap%0d.imem_addr", i), {8'd0, w_addr}, {8'd0, wrap_addr_exp[i]});
      end
      if (i >= 2 && i < 6) begin
        check($sformatf("wrap%0d.inst_valid", i), {15'd0, w_valid}, 16'd1);
        check($sformatf("wrap%0d.inst_pc", i), {8'd0, w_pc}, {8'd0, wrap_pc_exp[i-2]});
        check($sformatf("wrap%0d.inst", i), w_inst, 16'hA000 + {8'd0, wrap_pc_exp[i-2]});
      end
      @(posedge clk);
      #1;
    end

    // Fill the queue to two entries, then hit it with an async reset mid-cycle
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    @(negedge clk);
    check("fill1.imem_req", {15'd0, imem_req}, 16'd0);
    check("fill1.inst",     inst,              16'hA022);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fill2.imem_req",   {15'd0, imem_req},   16'd0);
    check("fill2.inst_valid", {15'd0, inst_valid}, 16'd1);
    check("fill2.inst",       inst,                16'hA022);
    check("fill2.inst_pc",    {8'd0, inst_pc},     16'h0022);
    #2 rst = 1'b1;
    #1;
    check("async.imem_req",   {15'd0, imem_req},   16'd0);
    check("async.inst_valid", {15'd0, inst_valid}, 16'd0);
    check("async.inst",       inst,                16'h0000);
    check("async.inst_pc",    {8'd0, inst_pc},     16'h0000);
    #1 rst = 1'b0;
    inst_ready = 1'b1;
    #1;
    check("post_rst0.imem_req",   {15'd0, imem_req},   16'd1);
    check("post_rst0.imem_addr",  {8'd0, imem_addr},   16'h0000);
    check("post_rst0.inst_valid", {15'd0, inst_valid}, 16'd0);
    @(negedge clk);
    check("post_rst1.imem_addr",  {8'd0, imem_addr},   16'h0001);
    check("post_rst1.inst_valid", {15'd0, inst_valid}, 16'd0);
    @(negedge clk);
    check("post_rst2.inst_valid", {15'd0, inst_valid}, 16'd1);
    check("post_rst2.inst",       inst,                16'hA000);
    check("post_rst2.inst_pc",    {8'd0, inst_pc},     16'h0000);
    check("post_rst2.imem_addr",  {8'd0, imem_addr},   16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues word reads to a fixed-latency instruction memory. Buffers returned 16-bit instruction words in a 2-entry queue and presents them with their PC over a valid/ready handshake to the decoder. A single-cycle redirect from execute restarts fetch at a new PC.

Parameters:
ADDR_W, 8, instruction memory word-address width; PC width
INST_W, 16, instruction word width (decoder format)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; asynchronous, active-high
imem_req  out  1  read request this cycle
imem_addr  out  ADDR_W  word address of request
imem_rdata  in  INST_W  read data, valid exactly 1 cycle after an accepted request
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new fetch PC
inst_valid  out  1  inst/inst_pc hold a valid instruction
inst_ready  in  1  decoder accepts this cycle
inst  out  INST_W  instruction word to decoder
inst_pc  out  ADDR_W  address of inst

Behaviour:
- Reset (async, any time, including mid-fetch): pc=RESET_PC, queue count=0, in-flight flag=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0. A response arriving in the first cycle after reset release is ignored because the in-flight flag is 0.
- Memory: no backpressure. A request in cycle t returns imem_rdata in t+1 unconditionally.
- pop = inst_valid & inst_ready.
- Issue rule: imem_req = !redirect_valid & (count + inflight - pop < 2). imem_addr = pc. pc advances by 1 on each issue and wraps modulo 2^ADDR_W (0xFF -> 0x00).
- Each request records {addr} in an in-flight register. The response is written to the queue tail with that PC in the return cycle unless it is killed.
- Queue: 2-entry FIFO. inst/inst_pc are the head entry, taken from registers. inst_valid = (count!=0) & !redirect_valid. Simultaneous push and pop with count=2 is legal and keeps count=2. Overflow cannot occur under the issue rule, and an assertion checks this.
- Latency: request in t -> inst_valid at t+2 when the queue is empty.
- Throughput: 1 instruction/cycle in steady state with inst_ready held high.
- Stall: with inst_ready=0, the queue fills to 2 and imem_req drops to 0. inst/inst_pc hold stable while valid and not accepted.
- Redirect (priority over everything) in cycle t:
  - imem_req=0 in t.
  - inst_valid forced 0 in t, so no pop occurs.
  - The queue is flushed at the t edge.
  - Any response returning in t is dropped, and the in-flight flag is cleared.
  - pc <= redirect_pc.
  - Cycle t+1: imem_req=1, imem_addr=redirect_pc.
  - Cycle t+3: inst_valid=1 with inst_pc=redirect_pc.
- Back-to-back redirects: the last one wins. Each redirect cycle repeats the flush.

Decomposition:
- Shared package cpu_pkg:
  - INST_W and ADDR_W constants.
  - Instruction field positions: cond [15:14], op_code [13:10], dest_reg [9:7], src_reg_1 [6:4], src_reg_2 [3:1], shift [0].
  - RESET_PC.
- One sub-module: fetch_queue, a 2-entry FIFO of {inst, pc} with push, pop, flush and count. The PC, issue logic and in-flight tracking stay in fetch_unit.

Test Plan:
- Reset then release, inst_ready=1, memory word[a]=0xA000+a -> imem_addr 0x00,0x01,0x02… one per cycle. First inst_valid two cycles after the first request with inst=0xA000, inst_pc=0x00. Then one instruction per cycle, in order, none lost or duplicated.
- inst_ready=0 for 5 cycles mid-stream -> exactly 2 queued plus no further requests. inst holds stable. On release, the sequence resumes with no gap or repeat.
- Redirect to 0x40 while the queue is full and a request is in flight -> no inst_valid in the redirect cycle. Next request address is 0x40. The next accepted instruction has inst_pc=0x40 and inst=0xA040, and no stale words appear.
- RESET_PC=0xFE, free-running -> addresses 0xFE, 0xFF, 0x00, 0x01, with inst_pc wrapping to match.
- Redirects to 0x10 then 0x20 on consecutive cycles -> first delivered inst_pc=0x20 and no 0x10 fetch occurs.
- rst asserted asynchronously between edges while count=2 -> outputs go to reset values immediately. After release, fetch restarts at RESET_PC and the response to the pre-reset request is ignored.
